// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
//
// Microprogram sequencer feeding the datapath control decoder. A small program
// of 8-bit words (bit7 = LAST, bits[6:0] = ctrl word) is loaded while the
// sequencer is not running. It is then replayed as a registered ctrl stream,
// one word per clock, for rpt+1 passes. Outside RUN the ctrl output holds
// NOP_WORD, so the register file never sees a spurious write.
//
// Optional feature: define CTRL_SEQUENCER_STEP_EN to add a 'step' input. In RUN,
// a word then issues only in cycles where step=1.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   load_en    write one program word this cycle (ignored in RUN)
//   load_addr  program address to write
//   load_data  bit7 = LAST flag, bits[6:0] = ctrl word
//   start      single-cycle pulse; begins execution at address 0 from IDLE
//   rpt        extra passes (total passes = rpt+1), sampled on start
//   step       (CTRL_SEQUENCER_STEP_EN only) issue enable in RUN
//   abort      terminate execution (RUN only)
//   ctrl       control word to the decoder (registered)
//   ctrl_valid ctrl holds a program word this cycle (registered)
//   busy       high while in RUN
//   done       one-cycle pulse when the last pass completes or an abort is taken
// -----------------------------------------------------------------------------
module ctrl_sequencer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AW       = 4,
   parameter logic [6:0]  NOP_WORD = 7'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   input  logic          start,
   input  logic [3:0]    rpt,
`ifdef CTRL_SEQUENCER_STEP_EN
   input  logic          step,
`endif
   input  logic          abort,
   output logic [6:0]    ctrl,
   output logic          ctrl_valid,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [3:0]    passes_q, passes_d;
   logic [6:0]    ctrl_q, ctrl_d;
   logic          ctrl_valid_q, ctrl_valid_d;
   logic          done_q, done_d;

   logic [7:0]    mem_q [DEPTH];
   logic          mem_we;
   logic [7:0]    cur_word;
   logic          word_end;
   logic          issue;

   // Writes are accepted in IDLE and DONE. A write in the same cycle as start
   // lands on this edge, before the first RUN cycle reads the memory.
   assign mem_we   = load_en && (state_q != S_RUN);
   assign cur_word = mem_q[pc_q];
   // The last address ends the program even without LAST, so pc never wraps.
   assign word_end = cur_word[7] | (pc_q == AW'(DEPTH - 1));

`ifdef CTRL_SEQUENCER_STEP_EN
   assign issue = step;
`else
   assign issue = 1'b1;
`endif

   // NOTE: program storage has no reset; it is always loaded before use and a
   // reset here would turn plain registers into far costlier resettable flops.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[load_addr] <= load_data;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      passes_d     = passes_q;
      ctrl_d       = NOP_WORD;
      ctrl_valid_d = 1'b0;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d     = '0;
               passes_d = rpt;
               state_d  = S_RUN;
            end
         end

         S_RUN: begin
            if (abort) begin
               // Abort pulses done on entry to DONE; DONE then stays quiet.
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (issue) begin
               ctrl_d       = cur_word[6:0];
               ctrl_valid_d = 1'b1;
               if (!word_end) begin
                  pc_d = pc_q + 1'b1;
               end else if (passes_q != 4'd0) begin
                  pc_d     = '0;
                  passes_d = passes_q - 4'd1;
               end else begin
                  pc_d    = '0;
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            // After a normal finish the last word is still on ctrl during
            // DONE, so done follows it. After an abort, done has already
            // pulsed and is not repeated.
            done_d  = !done_q;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         passes_q     <= '0;
         ctrl_q       <= NOP_WORD;
         ctrl_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         passes_q     <= passes_d;
         ctrl_q       <= ctrl_d;
         ctrl_valid_q <= ctrl_valid_d;
         done_q       <= done_d;
      end
   end

   assign ctrl       = ctrl_q;
   assign ctrl_valid = ctrl_valid_q;
   assign done       = done_q;
   assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ctrl_sequencer
//
// Directed testbench for ctrl_sequencer. Each run pushes its hand-computed
// ctrl words and a final done marker into a scoreboard queue. A monitor
// samples the DUT on the falling edge and pops one entry whenever ctrl_valid
// or done is high. It also flags gaps inside a burst and non-NOP ctrl values
// while idle.
// -----------------------------------------------------------------------------
module tb_ctrl_sequencer;

   logic       clk;
   logic       rst_n;
   logic       load_en;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic [3:0] rpt;
   logic       abort;
   logic [6:0] ctrl;
   logic       ctrl_valid;
   logic       busy;
   logic       done;
`ifdef CTRL_SEQUENCER_STEP_EN
   logic       step;
`endif

   typedef struct {
      logic       is_done;
      logic [6:0] word;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic in_burst = 1'b0;

   ctrl_sequencer #(.DEPTH(16), .AW(4), .NOP_WORD(7'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .rpt        (rpt),
`ifdef CTRL_SEQUENCER_STEP_EN
      .step       (step),
`endif
      .abort      (abort),
      .ctrl       (ctrl),
      .ctrl_valid (ctrl_valid),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [6:0] w);
      exp_t e;
      e.is_done = 1'b0;
      e.word    = w;
      sb.push_back(e);
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1;
      e.word    = 7'h00;
      sb.push_back(e);
   endtask

   // All driver tasks start and end on a falling edge.
   task automatic load_word(input logic [3:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic load_prog3();
      load_word(4'd0, 8'h12);
      load_word(4'd1, 8'h25);
      load_word(4'd2, 8'hC7);
   endtask

   task automatic push_prog3();
      push_word(7'h12);
      push_word(7'h25);
      push_word(7'h47);
   endtask

   task automatic pulse_start(input logic [3:0] r);
      start = 1'b1;
      rpt   = r;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input int cycles);
      repeat (cycles) @(negedge clk);
      check("drain_queue_empty", sb.size(), 0);
   endtask

   // Monitor: outputs only change on the rising edge, so falling-edge samples
   // are stable.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_burst = 1'b0;
      end else if (ctrl_valid || done) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {30'd0, ctrl_valid, done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_kind_done", done, e.is_done);
            check("out_valid", ctrl_valid, !e.is_done);
            check("out_ctrl", ctrl, e.word);
            in_burst = !e.is_done;
         end
      end else begin
         if (in_burst) begin
            check("bubble_in_burst", 1, 0);
            in_burst = 1'b0;
         end
         check("idle_ctrl_nop", ctrl, 7'h00);
      end
   end

   initial begin
      int seen;
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      rpt       = '0;
      abort     = 1'b0;
`ifdef CTRL_SEQUENCER_STEP_EN
      step      = 1'b1;
`endif

      // Reset values.
      #1;
      check("reset_ctrl", ctrl, 7'h00);
      check("reset_valid", ctrl_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic run: 12,25,47 then done.
      load_prog3();
      push_prog3();
      push_done();
      pulse_start(4'd0);
      check("busy_in_run", busy, 1);
      drain(6);
      check("busy_after_run", busy, 0);

      // Repeat: three passes back to back.
      push_prog3();
      push_prog3();
      push_prog3();
      push_done();
      pulse_start(4'd2);
      drain(14);

      // Implicit end: 16 words without LAST.
      for (int i = 0; i < 16; i++) begin
         load_word(4'(i), {1'b0, 7'(i * 5 + 3)});
         push_word(7'(i * 5 + 3));
      end
      push_done();
      pulse_start(4'd0);
      drain(20);

      // Abort on the second valid cycle of a two-pass run.
      load_prog3();
      push_word(7'h12);
      push_word(7'h25);
      push_done();
      pulse_start(4'd1);
      seen = 0;
      for (int k = 0; k < 10 && seen < 2; k++) begin
         if (ctrl_valid) seen++;
         if (seen < 2) @(negedge clk);
      end
      check("abort_point_reached", seen, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("busy_after_abort", busy, 0);
      drain(4);

      // Load and start during RUN are ignored.
      push_prog3();
      push_prog3();
      push_done();
      pulse_start(4'd1);
      @(negedge clk);
      load_word(4'd1, 8'h7F);
      start = 1'b1;
      rpt   = 4'hF;
      @(negedge clk);
      start = 1'b0;
      drain(12);
      push_prog3();
      push_done();
      pulse_start(4'd0);
      drain(6);

      // Load and start together: execution sees the new word.
      push_word(7'h1A);
      push_done();
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = 8'h9A;
      start     = 1'b1;
      rpt       = 4'd0;
      @(negedge clk);
      load_en = 1'b0;
      start   = 1'b0;
      drain(5);

      // Asynchronous reset in the middle of a 4-word run.
      load_word(4'd0, 8'h01);
      load_word(4'd1, 8'h02);
      load_word(4'd2, 8'h03);
      load_word(4'd3, 8'h84);
      for (int p = 0; p < 4; p++) begin
         push_word(7'h01);
         push_word(7'h02);
         push_word(7'h03);
         push_word(7'h04);
      end
      push_done();
      pulse_start(4'd3);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun_reset_ctrl", ctrl, 7'h00);
      check("midrun_reset_valid", ctrl_valid, 0);
      check("midrun_reset_busy", busy, 0);
      check("midrun_reset_done", done, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", busy, 0);
      push_word(7'h01);
      push_word(7'h02);
      push_word(7'h03);
      push_word(7'h04);
      push_done();
      pulse_start(4'd0);
      drain(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Microprogram sequencer that sits directly upstream of the datapath control decoder.
- Stores a short program of 7-bit control words: opcode[6:4], waddr/opsel-select[3:2], aaddr/shift-select[1:0].
- Replays the program as a registered ctrl[6:0] stream, one word per clock, with a repeat count and abort.
- Drives the decoder's ctrl input. Outside RUN it holds a NOP word so the register file sees no spurious writes.

Parameters:
- DEPTH, 16, number of program words; power of two, minimum 2.
- AW, 4, program address width; equals log2(DEPTH).
- NOP_WORD, 7'h00, ctrl value driven whenever no instruction is issued.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  write one program word this cycle.
- load_addr  input  AW  program address to write.
- load_data  input  8  bit7 = LAST flag; bits[6:0] = ctrl word.
- start  input  1  begin execution at address 0. Single-cycle pulse.
- rpt  input  4  extra passes; total passes = rpt+1. Sampled on start.
- abort  input  1  terminate execution.
- ctrl  output  7  control word to the decoder.
- ctrl_valid  output  1  ctrl holds a program word this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the final pass completes or an abort is taken.

Behaviour:
- Reset:
  - State IDLE, pc=0, pass counter=0.
  - ctrl=NOP_WORD, ctrl_valid=0, busy=0, done=0.
  - Program memory contents are not reset. The bench must load before start.
- Memory: DEPTH x 8 registers. The write happens on the clock edge when load_en=1 and state is IDLE or DONE. Writes are ignored in RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start: pc<=0, passes<=rpt, go RUN.
  - If start and load_en are both asserted, the write completes first. Execution therefore sees the new word.
- RUN, every cycle:
  - ctrl<=mem[pc][6:0], ctrl_valid<=1.
  - Word end = mem[pc][7] | (pc==DEPTH-1). Reaching the last address without LAST acts as an implicit LAST; pc never wraps silently.
  - Not end: pc<=pc+1.
  - End and passes!=0: pc<=0, passes<=passes-1. The next word follows with no bubble.
  - End and passes==0: go DONE.
- DONE:
  - Lasts one cycle: done=1, ctrl=NOP_WORD, ctrl_valid=0, then go IDLE.
  - A start seen in DONE is ignored.
- Latency: start sampled at edge N → ctrl=mem[0] is visible after edge N+1. The final word is visible for one cycle, then done=1 with NOP.
- Issue count: program length L with rpt=R gives exactly L*(R+1) valid ctrl cycles.
- abort:
  - In RUN, abort has priority over everything: the next state is DONE, ctrl=NOP_WORD, ctrl_valid=0, and done pulses once.
  - In IDLE or DONE, abort is ignored.
- start while busy: ignored, with no restart.
- Asynchronous reset mid-RUN: immediate return to the reset values. ctrl=NOP_WORD with no glitch through other values.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CTRL_SEQUENCER_STEP_EN.
- With the macro defined:
  - Adds input port step (1 bit).
  - In RUN, a word issues only in a cycle where step=1. Otherwise ctrl=NOP_WORD, ctrl_valid=0, and pc/passes hold.
  - abort still acts regardless of step.
- Without the macro: no step port; RUN issues every cycle.

Test Plan:
- Reset: rst_n=0 mid-RUN of a 4-word program → ctrl=7'h00, ctrl_valid=0, busy=0 immediately. After release, state is IDLE.
- Basic run:
  - Stimulus: load addr0..2 = 8'h12, 8'h25, 8'hC7 (LAST on addr2), rpt=0, start.
  - Response: ctrl = 7'h12, 7'h25, 7'h47 on 3 consecutive cycles with ctrl_valid=1, then done=1 for one cycle with ctrl=7'h00.
- Repeat: same program, rpt=2 → 9 valid cycles in the pattern 12,25,47 x3 with no bubbles; done one cycle after the 9th.
- Implicit end: DEPTH=16, no LAST bit set, rpt=0 → 16 valid words from addr0..15, then done.
- Abort: abort asserted on the 2nd valid cycle of a 3-word program → the next cycle has ctrl_valid=0, done=1, and ctrl=7'h00; the 3rd word never issues.
- Ignored inputs: load_en to addr1 during RUN → execution is unchanged, and a later run still issues the original word. start during RUN → no restart and no extra words.
